// File: rtl/huff_tree_merge.sv
// huff_tree_merge: sequential Huffman tree builder.
// Takes a weight-sorted list of up to four entries {weight, id}. It repeatedly
// merges the two lightest entries into a new parent node, emits each merge
// record over a valid/ready handshake, and reports the surviving root.
// Optional build macro HUFF_MERGE_SAT_EN: parent weights saturate at all-ones
// instead of wrapping. ovf flags the carry out in both builds.
module huff_tree_merge #(
    parameter int DSIZE = 18,
    parameter int OFFSET = 8,
    parameter logic [OFFSET-1:0] NODE_BASE = 8'h80
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [DSIZE-1:0]          in0,
    input  logic [DSIZE-1:0]          in1,
    input  logic [DSIZE-1:0]          in2,
    input  logic [DSIZE-1:0]          in3,
    input  logic [2:0]                in_count,
    output logic                      merge_valid,
    input  logic                      merge_ready,
    output logic [OFFSET-1:0]         merge_left,
    output logic [OFFSET-1:0]         merge_right,
    output logic [OFFSET-1:0]         merge_node,
    output logic [DSIZE-OFFSET-1:0]   merge_weight,
    output logic                      root_valid,
    output logic [OFFSET-1:0]         root_id,
    output logic [DSIZE-OFFSET-1:0]   root_weight,
    output logic                      root_err,
    output logic                      ovf
);
    localparam int W = DSIZE - OFFSET;

    typedef enum logic [1:0] {IDLE, MERGE, INSERT, DONE} state_t;

    state_t            state;
    // Entries not yet consumed by the pending merge; the two lightest live in the merge record.
    logic [DSIZE-1:0]  rest0, rest1;
    logic [2:0]        cnt;
    logic [OFFSET-1:0] next_id;

    logic [DSIZE-1:0]  new_entry, ins0, ins1, ins2, src_a, src_b;
    logic [1:0]        pos;
    logic [W:0]        sum_full;
    logic [W-1:0]      sum_w;

    // Sorted re-insertion of the parent and the next pair sum.
    always_comb begin
        new_entry = {merge_weight, merge_node};
        pos = 2'd0;
        // The new node goes behind every remaining entry of equal or lower weight.
        if (cnt >= 3'd3 && rest0[DSIZE-1:OFFSET] <= merge_weight) pos = 2'd1;
        if (cnt >= 3'd4 && rest1[DSIZE-1:OFFSET] <= merge_weight) pos = 2'd2;
        ins0 = (pos == 2'd0) ? new_entry : rest0;
        ins1 = (pos == 2'd2) ? rest1 : ((pos == 2'd1) ? new_entry : rest0);
        ins2 = (pos == 2'd2) ? new_entry : rest1;
        src_a = (state == IDLE) ? in0 : ins0;
        src_b = (state == IDLE) ? in1 : ins1;
        sum_full = {1'b0, src_a[DSIZE-1:OFFSET]} + {1'b0, src_b[DSIZE-1:OFFSET]};
`ifdef HUFF_MERGE_SAT_EN
        sum_w = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
        sum_w = sum_full[W-1:0];
`endif
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            load_ready   <= 1'b1;
            merge_valid  <= 1'b0;
            merge_left   <= '0;
            merge_right  <= '0;
            merge_node   <= '0;
            merge_weight <= '0;
            root_valid   <= 1'b0;
            root_id      <= '0;
            root_weight  <= '0;
            root_err     <= 1'b0;
            ovf          <= 1'b0;
            rest0        <= '0;
            rest1        <= '0;
            cnt          <= '0;
            next_id      <= '0;
        end else begin
            root_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        load_ready <= 1'b0;
                        rest0      <= in2;
                        rest1      <= in3;
                        cnt        <= in_count;
                        next_id    <= NODE_BASE;
                        ovf        <= 1'b0;
                        root_err   <= 1'b0;
                        case (in_count)
                            3'd2, 3'd3, 3'd4: begin
                                state        <= MERGE;
                                merge_valid  <= 1'b1;
                                merge_left   <= in0[OFFSET-1:0];
                                merge_right  <= in1[OFFSET-1:0];
                                merge_node   <= NODE_BASE;
                                merge_weight <= sum_w;
                                ovf          <= sum_full[W];
                            end
                            3'd1: begin
                                state       <= DONE;
                                root_valid  <= 1'b1;
                                root_id     <= in0[OFFSET-1:0];
                                root_weight <= in0[DSIZE-1:OFFSET];
                            end
                            default: begin
                                state       <= DONE;
                                root_valid  <= 1'b1;
                                root_err    <= 1'b1;
                                root_id     <= '0;
                                root_weight <= '0;
                            end
                        endcase
                    end
                end
                MERGE: begin
                    if (merge_ready) begin
                        merge_valid <= 1'b0;
                        state       <= INSERT;
                    end
                end
                INSERT: begin
                    rest0   <= ins2;
                    cnt     <= cnt - 3'd1;
                    next_id <= next_id + 1'b1;
                    if (cnt == 3'd2) begin
                        state       <= DONE;
                        root_valid  <= 1'b1;
                        root_id     <= ins0[OFFSET-1:0];
                        root_weight <= ins0[DSIZE-1:OFFSET];
                    end else begin
                        state        <= MERGE;
                        merge_valid  <= 1'b1;
                        merge_left   <= ins0[OFFSET-1:0];
                        merge_right  <= ins1[OFFSET-1:0];
                        merge_node   <= next_id + 1'b1;
                        merge_weight <= sum_w;
                        ovf          <= ovf | sum_full[W];
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    load_ready <= 1'b1;
                    root_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_huff_tree_merge.sv
// Testbench for huff_tree_merge: scenario tasks against a list-based Huffman model.
module tb_huff_tree_merge;
    localparam int DSIZE = 18;
    localparam int OFFSET = 8;
    localparam int W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [DSIZE-1:0]  in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic [2:0]        in_count = '0;
    logic              merge_valid;
    logic              merge_ready = 1'b0;
    logic [OFFSET-1:0] merge_left, merge_right, merge_node;
    logic [W-1:0]      merge_weight;
    logic              root_valid;
    logic [OFFSET-1:0] root_id;
    logic [W-1:0]      root_weight;
    logic              root_err;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    huff_tree_merge dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in_count(in_count),
        .merge_valid(merge_valid), .merge_ready(merge_ready),
        .merge_left(merge_left), .merge_right(merge_right), .merge_node(merge_node),
        .merge_weight(merge_weight), .root_valid(root_valid), .root_id(root_id),
        .root_weight(root_weight), .root_err(root_err), .ovf(ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DSIZE-1:0] ent(input int w, input int id);
        logic [W-1:0] wv;
        logic [OFFSET-1:0] iv;
        wv = w[W-1:0];
        iv = id[OFFSET-1:0];
        return {wv, iv};
    endfunction

    // mode 0: always ready, 1: random ready and spurious loads, 2: stall first merge 5 cycles
    task automatic run_tree(input logic [DSIZE-1:0] e0, input logic [DSIZE-1:0] e1,
                            input logic [DSIZE-1:0] e2, input logic [DSIZE-1:0] e3,
                            input int cnt_in, input int mode, input string tag);
        logic [DSIZE-1:0] src[4];
        logic [DSIZE-1:0] q[$];
        logic [DSIZE-1:0] a, b;
        int exp_l[$], exp_r[$], exp_n[$], exp_w[$];
        bit exp_o[$];
        int s, sw, p, nid, root_i, root_w, n_eff, mi, ticks, stalls, hold;
        bit err, ovf_acc, done, rdy;
        src = '{e0, e1, e2, e3};
        nid = 'h80;
        ovf_acc = 0;
        if (cnt_in >= 1 && cnt_in <= 4) begin
            for (int i = 0; i < cnt_in; i++) q.push_back(src[i]);
            while (q.size() > 1) begin
                a = q.pop_front();
                b = q.pop_front();
                s = int'(a[DSIZE-1:OFFSET]) + int'(b[DSIZE-1:OFFSET]);
                if (s > 1023) ovf_acc = 1;
`ifdef HUFF_MERGE_SAT_EN
                sw = (s > 1023) ? 1023 : s;
`else
                sw = s % 1024;
`endif
                exp_l.push_back(int'(a[OFFSET-1:0]));
                exp_r.push_back(int'(b[OFFSET-1:0]));
                exp_n.push_back(nid);
                exp_w.push_back(sw);
                exp_o.push_back(ovf_acc);
                p = 0;
                foreach (q[k]) if (int'(q[k][DSIZE-1:OFFSET]) <= sw) p = k + 1;
                q.insert(p, ent(sw, nid));
                nid = (nid + 1) % 256;
            end
            root_i = int'(q[0][OFFSET-1:0]);
            root_w = int'(q[0][DSIZE-1:OFFSET]);
            err = 0;
            n_eff = cnt_in;
        end else begin
            root_i = 0;
            root_w = 0;
            err = 1;
            n_eff = 1;
        end

        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s load_ready_idle: got %b expected 1", tag, load_ready);
        end
        in0 = e0; in1 = e1; in2 = e2; in3 = e3;
        in_count = cnt_in[2:0];
        load_valid = 1'b1;
        merge_ready = 1'b1;
        tick();
        load_valid = 1'b0;
        in0 = $urandom; in1 = $urandom; in2 = $urandom; in3 = $urandom;
        in_count = 3'($urandom_range(0, 7));

        mi = 0; ticks = 0; stalls = 0; hold = 0; done = 0;
        while (!done && ticks < 300) begin
            if (merge_valid) begin
                checks++;
                if (mi >= exp_l.size()) begin
                    errors++;
                    $display("FAIL %s unexpected_merge: got record %0d expected only %0d", tag, mi, exp_l.size());
                end else if (int'(merge_left) !== exp_l[mi] || int'(merge_right) !== exp_r[mi] ||
                             int'(merge_node) !== exp_n[mi] || int'(merge_weight) !== exp_w[mi] ||
                             ovf !== exp_o[mi]) begin
                    errors++;
                    $display("FAIL %s merge%0d: got l=%h r=%h n=%h w=%0d ovf=%b expected l=%h r=%h n=%h w=%0d ovf=%b",
                             tag, mi, merge_left, merge_right, merge_node, merge_weight, ovf,
                             exp_l[mi], exp_r[mi], exp_n[mi], exp_w[mi], exp_o[mi]);
                end
                if (mode == 1) rdy = 1'($urandom_range(0, 1));
                else if (mode == 2) rdy = !(mi == 0 && hold < 5);
                else rdy = 1'b1;
                if (!rdy) begin stalls++; hold++; end
                else mi++;
                merge_ready = rdy;
            end else begin
                merge_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (root_valid) begin
                checks++;
                if (int'(root_id) !== root_i || int'(root_weight) !== root_w || root_err !== err ||
                    ovf !== ovf_acc || mi !== exp_l.size() || ticks !== 2 * (n_eff - 1) + stalls) begin
                    errors++;
                    $display("FAIL %s root: got id=%h w=%0d err=%b ovf=%b merges=%0d cyc=%0d expected id=%h w=%0d err=%b ovf=%b merges=%0d cyc=%0d",
                             tag, root_id, root_weight, root_err, ovf, mi, ticks,
                             root_i, root_w, err, ovf_acc, exp_l.size(), 2 * (n_eff - 1) + stalls);
                end
                done = 1;
                load_valid = 1'b0;
            end else if (mode == 1) begin
                load_valid = 1'($urandom_range(0, 1));
            end
            tick();
            ticks++;
        end
        load_valid = 1'b0;
        merge_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: got no root_valid expected root within 300 cycles", tag);
        end else if (root_valid !== 1'b0 || load_ready !== 1'b1 || merge_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after_root: got rv=%b lr=%b mv=%b expected rv=0 lr=1 mv=0",
                     tag, root_valid, load_ready, merge_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if (load_ready !== 1'b1 || merge_valid !== 1'b0 || root_valid !== 1'b0 || root_err !== 1'b0 ||
            ovf !== 1'b0 || merge_left !== '0 || merge_right !== '0 || merge_node !== '0 ||
            merge_weight !== '0 || root_id !== '0 || root_weight !== '0) begin
            errors++;
            $display("FAIL reset_values: got lr=%b mv=%b rv=%b err=%b ovf=%b l=%h r=%h n=%h w=%0d id=%h rw=%0d expected lr=1 rest 0",
                     load_ready, merge_valid, root_valid, root_err, ovf, merge_left, merge_right,
                     merge_node, merge_weight, root_id, root_weight);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        run_tree(ent(1, 0), ent(2, 1), ent(3, 2), ent(4, 3), 4, 0, "basic");
    endtask

    task automatic test_ties;
        run_tree(ent(2, 0), ent(2, 1), ent(2, 2), ent(2, 3), 4, 0, "ties");
    endtask

    task automatic test_backpressure;
        run_tree(ent(1, 0), ent(2, 1), ent(3, 2), ent(4, 3), 4, 2, "backpressure");
    endtask

    task automatic test_overflow;
        run_tree(ent(1023, 7), ent(1023, 9), ent(0, 0), ent(0, 0), 2, 0, "overflow");
    endtask

    task automatic test_degenerate;
        run_tree(ent(9, 5), ent(1, 1), ent(2, 2), ent(3, 3), 1, 0, "count1");
        run_tree(ent(9, 5), ent(1, 1), ent(2, 2), ent(3, 3), 0, 0, "count0");
        run_tree(ent(1, 1), ent(2, 2), ent(3, 3), ent(4, 4), 6, 0, "count6");
    endtask

    task automatic test_reset_mid;
        in0 = ent(1, 0); in1 = ent(2, 1); in2 = ent(3, 2); in3 = ent(4, 3);
        in_count = 3'd4;
        load_valid = 1'b1;
        merge_ready = 1'b0;
        tick();
        load_valid = 1'b0;
        checks++;
        if (merge_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got merge_valid=%b expected 1", merge_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (load_ready !== 1'b1 || merge_valid !== 1'b0 || root_valid !== 1'b0 || ovf !== 1'b0 ||
            merge_left !== '0 || merge_right !== '0 || merge_node !== '0 || merge_weight !== '0 ||
            root_id !== '0 || root_weight !== '0 || root_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got lr=%b mv=%b rv=%b l=%h r=%h n=%h w=%0d expected lr=1 rest 0",
                     load_ready, merge_valid, root_valid, merge_left, merge_right, merge_node, merge_weight);
        end
        merge_ready = 1'b1;
        tick(); tick();
        checks++;
        if (root_valid !== 1'b0 || merge_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: got rv=%b mv=%b expected 0 0", root_valid, merge_valid);
        end
        rst_n = 1'b1;
        merge_ready = 1'b0;
        tick();
        run_tree(ent(5, 10), ent(6, 11), ent(7, 12), ent(20, 13), 4, 0, "after_reset");
    endtask

    task automatic test_random;
        int w[4];
        int t, n, tmp;
        logic [DSIZE-1:0] e[4];
        for (t = 0; t < 40; t++) begin
            n = $urandom_range(1, 4);
            if (t % 13 == 12) n = (t % 2 == 0) ? 0 : 7;
            for (int i = 0; i < 4; i++)
                w[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 7);
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3 - i; j++)
                    if (w[j] > w[j + 1]) begin tmp = w[j]; w[j] = w[j + 1]; w[j + 1] = tmp; end
            for (int i = 0; i < 4; i++) e[i] = ent(w[i], $urandom_range(0, 255));
            run_tree(e[0], e[1], e[2], e[3], n, 1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_backpressure();
        test_overflow();
        test_degenerate();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
